// File: rtl/mips_cpu_register_file_mp.sv
// mips_cpu_register_file_mp: multi-port register file with merge writes, bypass, load scoreboard and sweep clear
module mips_cpu_register_file_mp #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_READ   = 2,
  parameter int BYPASS     = 1,
  parameter int V0_INDEX   = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] read_addr,
  output logic [NUM_READ*DATA_WIDTH-1:0] read_data,
  output logic [NUM_READ-1:0]            read_busy,
  output logic [DATA_WIDTH-1:0]          read_data_v0,
  input  logic                           write_enable,
  input  logic [1:0]                     write_mode,
  input  logic [DATA_WIDTH/8-1:0]        write_byte_en,
  input  logic [ADDR_WIDTH-1:0]          write_reg,
  input  logic [DATA_WIDTH-1:0]          write_data,
  input  logic                           mark_busy,
  input  logic [ADDR_WIDTH-1:0]          mark_reg,
  input  logic                           clear_req,
  output logic                           clear_active,
  output logic                           write_ready
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int NB = DATA_WIDTH / 8;
  localparam bit BYP = BYPASS != 0;
  localparam logic [ADDR_WIDTH-1:0] V0_A = ADDR_WIDTH'(V0_INDEX);

  if (V0_INDEX < 0 || V0_INDEX >= DEPTH) begin : g_bad_v0
    $error("V0_INDEX out of range");
  end
  if (DATA_WIDTH % 8 != 0 || NUM_READ < 1 || NUM_READ > 4) begin : g_bad_cfg
    $error("invalid DATA_WIDTH or NUM_READ");
  end

  typedef enum logic {IDLE, SWEEP} state_t;
  state_t state;
  logic [ADDR_WIDTH-1:0] cnt;
  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] busy;
  logic [DATA_WIDTH-1:0] old_val, lane_val, new_val;
  logic commit;

  assign clear_active = state == SWEEP;
  assign write_ready  = state == IDLE;
  assign commit = write_enable && write_ready && write_reg != '0;

  always_comb begin
    old_val = regs[write_reg];
    lane_val = old_val;
    for (int i = 0; i < NB; i++)
      lane_val[i*8 +: 8] = write_byte_en[i] ? write_data[i*8 +: 8] : old_val[i*8 +: 8];
    new_val = write_mode == 2'd1 ? (write_data | old_val) :
              write_mode == 2'd2 ? lane_val : write_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      busy  <= '0;
      state <= IDLE;
      cnt   <= '0;
    end else begin
      if (commit) begin
        regs[write_reg] <= new_val;
        busy[write_reg] <= 1'b0;
      end
      if (state == SWEEP) begin
        regs[cnt] <= '0;
        busy[cnt] <= 1'b0;
        cnt <= cnt + 1'b1;
        if (&cnt) state <= IDLE;
      end else if (clear_req) begin
        state <= SWEEP;
        cnt   <= ADDR_WIDTH'(1);
      end
      // placed last so a new load mark beats a same-edge clear
      if (mark_busy && mark_reg != '0) busy[mark_reg] <= 1'b1;
    end
  end

  for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
    logic [ADDR_WIDTH-1:0] a;
    logic hit;
    assign a = read_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
    assign hit = BYP && commit && a == write_reg;
    assign read_data[k*DATA_WIDTH +: DATA_WIDTH] = a == '0 ? '0 : hit ? new_val : regs[a];
    assign read_busy[k] = a == '0 ? 1'b0 : hit ? (mark_busy && mark_reg == a) : busy[a];
  end

  assign read_data_v0 = V0_A == '0 ? '0 :
                        (BYP && commit && write_reg == V0_A) ? new_val : regs[V0_A];
endmodule

// File: tb/tb_mips_cpu_register_file_mp.sv
// tb_mips_cpu_register_file_mp: directed vectors plus sweep/reset/bypass sequences on BYPASS=1 and BYPASS=0 builds
module tb_mips_cpu_register_file_mp;
  logic clk = 1'b0;
  logic reset;
  logic [9:0] read_addr;
  logic [63:0] read_data, read_data_b0;
  logic [1:0] read_busy, read_busy_b0;
  logic [31:0] v0, v0_b0;
  logic write_enable;
  logic [1:0] write_mode;
  logic [3:0] write_byte_en;
  logic [4:0] write_reg;
  logic [31:0] write_data;
  logic mark_busy;
  logic [4:0] mark_reg;
  logic clear_req;
  logic clear_active, write_ready, clear_active_b0, write_ready_b0;
  int passed = 0;
  int total = 0;

  always #5 clk = ~clk;

  mips_cpu_register_file_mp #(.BYPASS(1)) dut (
    .clk(clk), .reset(reset), .read_addr(read_addr), .read_data(read_data),
    .read_busy(read_busy), .read_data_v0(v0), .write_enable(write_enable),
    .write_mode(write_mode), .write_byte_en(write_byte_en), .write_reg(write_reg),
    .write_data(write_data), .mark_busy(mark_busy), .mark_reg(mark_reg),
    .clear_req(clear_req), .clear_active(clear_active), .write_ready(write_ready));

  mips_cpu_register_file_mp #(.BYPASS(0)) dut_b0 (
    .clk(clk), .reset(reset), .read_addr(read_addr), .read_data(read_data_b0),
    .read_busy(read_busy_b0), .read_data_v0(v0_b0), .write_enable(write_enable),
    .write_mode(write_mode), .write_byte_en(write_byte_en), .write_reg(write_reg),
    .write_data(write_data), .mark_busy(mark_busy), .mark_reg(mark_reg),
    .clear_req(clear_req), .clear_active(clear_active_b0), .write_ready(write_ready_b0));

  typedef struct {
    logic we; logic [1:0] mode; logic [3:0] be; logic [4:0] wr; logic [31:0] wd;
    logic [4:0] ra0; logic [4:0] ra1; logic [31:0] e0; logic [31:0] e1;
  } vec_t;
  vec_t vt [11];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic step(input logic we, input logic [1:0] mode, input logic [3:0] be,
                      input logic [4:0] wr, input logic [31:0] wd,
                      input logic mb, input logic [4:0] mr, input logic clr);
    @(negedge clk);
    write_enable = we; write_mode = mode; write_byte_en = be; write_reg = wr;
    write_data = wd; mark_busy = mb; mark_reg = mr; clear_req = clr;
    @(posedge clk);
    #1;
    write_enable = 1'b0; mark_busy = 1'b0; clear_req = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
    read_addr = {a1, a0};
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    logic [31:0] acc_d;
    logic acc_b;
    acc_d = '0; acc_b = 1'b0;
    for (int i = 1; i < 32; i++) begin
      rd(5'(i), 5'(i));
      acc_d = acc_d | read_data[31:0] | read_data_b0[31:0];
      acc_b = acc_b | read_busy[0] | read_busy_b0[0];
    end
    chk({tag, "_regs_zero"}, acc_d, 32'h0);
    chk({tag, "_busy_zero"}, {31'b0, acc_b}, 32'h0);
  endtask

  initial begin
    int n, hi;
    vt[0]  = '{1'b1, 2'd0, 4'hf, 5'd5,  32'h12345678, 5'd5,  5'd0, 32'h12345678, 32'h0};
    vt[1]  = '{1'b1, 2'd0, 4'hf, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd5, 32'h0, 32'h12345678};
    vt[2]  = '{1'b1, 2'd0, 4'hf, 5'd7,  32'h00F000F0, 5'd7,  5'd5, 32'h00F000F0, 32'h12345678};
    vt[3]  = '{1'b1, 2'd1, 4'h0, 5'd7,  32'h0F000F00, 5'd7,  5'd0, 32'h0FF00FF0, 32'h0};
    vt[4]  = '{1'b1, 2'd2, 4'h5, 5'd7,  32'hAABBCCDD, 5'd7,  5'd5, 32'h0FBB0FDD, 32'h12345678};
    vt[5]  = '{1'b1, 2'd3, 4'h0, 5'd7,  32'h11223344, 5'd7,  5'd0, 32'h11223344, 32'h0};
    vt[6]  = '{1'b1, 2'd2, 4'hf, 5'd8,  32'hCAFEF00D, 5'd8,  5'd7, 32'hCAFEF00D, 32'h11223344};
    vt[7]  = '{1'b1, 2'd2, 4'h0, 5'd8,  32'hFFFFFFFF, 5'd8,  5'd0, 32'hCAFEF00D, 32'h0};
    vt[8]  = '{1'b1, 2'd1, 4'h0, 5'd8,  32'h00000001, 5'd8,  5'd5, 32'hCAFEF00D, 32'h12345678};
    vt[9]  = '{1'b0, 2'd0, 4'hf, 5'd5,  32'h00000000, 5'd5,  5'd8, 32'h12345678, 32'hCAFEF00D};
    vt[10] = '{1'b1, 2'd0, 4'hf, 5'd31, 32'h80000001, 5'd31, 5'd7, 32'h80000001, 32'h11223344};
    reset = 1'b1; read_addr = '0; write_enable = 1'b0; write_mode = '0; write_byte_en = '0;
    write_reg = '0; write_data = '0; mark_busy = 1'b0; mark_reg = '0; clear_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    rd(5'd5, 5'd9);
    chk("rst_clear_active", {31'b0, clear_active}, 32'h0);
    chk("rst_write_ready", {31'b0, write_ready}, 32'h1);
    chk("rst_read", read_data[31:0] | read_data[63:32], 32'h0);
    chk("rst_v0", v0, 32'h0);
    chk("rst_busy", {30'b0, read_busy}, 32'h0);

    for (int i = 0; i < 11; i++) begin
      step(vt[i].we, vt[i].mode, vt[i].be, vt[i].wr, vt[i].wd, 1'b0, 5'd0, 1'b0);
      rd(vt[i].ra0, vt[i].ra1);
      chk($sformatf("vec%0d_p0", i), read_data[31:0], vt[i].e0);
      chk($sformatf("vec%0d_p1", i), read_data[63:32], vt[i].e1);
      chk($sformatf("vec%0d_b0_p0", i), read_data_b0[31:0], vt[i].e0);
    end

    // same-cycle bypass: BYPASS=1 sees new value, BYPASS=0 still old
    @(negedge clk);
    read_addr = {5'd0, 5'd2};
    write_enable = 1'b1; write_mode = 2'd0; write_reg = 5'd2; write_data = 32'hDEADBEEF;
    #1;
    chk("byp_p0", read_data[31:0], 32'hDEADBEEF);
    chk("byp_v0", v0, 32'hDEADBEEF);
    chk("nobyp_p0_old", read_data_b0[31:0], 32'h0);
    chk("nobyp_v0_old", v0_b0, 32'h0);
    @(posedge clk);
    #1 write_enable = 1'b0;
    #1;
    chk("nobyp_p0_new", read_data_b0[31:0], 32'hDEADBEEF);
    chk("nobyp_v0_new", v0_b0, 32'hDEADBEEF);

    // scoreboard
    step(1'b0, 2'd0, 4'h0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b0);
    rd(5'd9, 5'd0);
    chk("mark_r9", {30'b0, read_busy}, 32'h1);
    step(1'b1, 2'd0, 4'hf, 5'd9, 32'h99, 1'b1, 5'd9, 1'b0);
    chk("wr_mark_same", {31'b0, read_busy[0]}, 32'h1);
    @(negedge clk);
    write_enable = 1'b1; write_reg = 5'd9; write_data = 32'h9A;
    #1;
    chk("byp_busy_post", {31'b0, read_busy[0]}, 32'h0);
    chk("nobyp_busy_pre", {31'b0, read_busy_b0[0]}, 32'h1);
    @(posedge clk);
    #1 write_enable = 1'b0;
    #1;
    chk("wr_clears_busy", {30'b0, read_busy_b0}, 32'h0);
    step(1'b0, 2'd0, 4'h0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b0);
    rd(5'd0, 5'd0);
    chk("mark_r0_ignored", {30'b0, read_busy}, 32'h0);

    // full sweep: fill, mark, write+clear on same edge, drop write and re-request mid-sweep
    for (int i = 1; i < 32; i++) step(1'b1, 2'd0, 4'hf, 5'(i), 32'h01010101 * i, 1'b0, 5'd0, 1'b0);
    step(1'b0, 2'd0, 4'h0, 5'd0, 32'h0, 1'b1, 5'd4, 1'b0);
    step(1'b1, 2'd0, 4'hf, 5'd6, 32'h66666666, 1'b0, 5'd0, 1'b1);
    rd(5'd6, 5'd20);
    chk("same_edge_wr", read_data[31:0], 32'h66666666);
    chk("sweep_partial", read_data[63:32], 32'h14141414);
    n = 0; hi = 0;
    while (clear_active && n < 100) begin
      hi++;
      if (write_ready) chk("sweep_write_ready", {31'b0, write_ready}, 32'h0);
      @(negedge clk);
      if (n == 10) begin
        write_enable = 1'b1; write_reg = 5'd3; write_data = 32'hFFFFFFFF; clear_req = 1'b1;
      end
      @(posedge clk);
      #1 write_enable = 1'b0; clear_req = 1'b0;
      n++;
    end
    chk("sweep_cycles", 32'(hi), 32'd31);
    chk("after_sweep_ready", {30'b0, clear_active, write_ready}, 32'h1);
    check_all_zero("sweep");

    // reset ten cycles into a sweep
    for (int i = 1; i < 32; i++) step(1'b1, 2'd0, 4'hf, 5'(i), ~(32'h01010101 * i), 1'b0, 5'd0, 1'b0);
    step(1'b0, 2'd0, 4'h0, 5'd0, 32'h0, 1'b1, 5'd20, 1'b1);
    repeat (9) step(1'b0, 2'd0, 4'h0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
    chk("pre_reset_active", {31'b0, clear_active}, 32'h1);
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    chk("mid_reset_state", {30'b0, clear_active, write_ready}, 32'h1);
    check_all_zero("mid_reset");
    step(1'b0, 2'd0, 4'h0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
    chk("mid_reset_stays_idle", {31'b0, clear_active}, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/mips_cpu_register_file_mp.md
Name: mips_cpu_register_file_mp

Overview:
- Parametrised, multi-read-port successor to the CPU's general-purpose register file.
- Adds three things: configurable width/depth/read-port count, a byte-lane merge write mode (for LWL/LWR-style partial writes) alongside plain and OR writes, and optional write-to-read bypass.
- Also adds a per-register pending-load scoreboard for hazard detection and a one-register-per-cycle soft-clear sweep engine.
- Sits between decode (reads), writeback (writes) and the hazard/stall unit (busy bits).

Parameters:
DATA_WIDTH, 32, register width in bits; must be a multiple of 8
ADDR_WIDTH, 5, register index width; DEPTH = 2**ADDR_WIDTH
NUM_READ, 2, number of independent read ports (1..4)
BYPASS, 1, 1 = same-cycle write data visible on read ports; 0 = reads return the pre-write value
V0_INDEX, 2, register mirrored on read_data_v0

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
read_addr  in  NUM_READ*ADDR_WIDTH  packed read indices; port k uses slice k
read_data  out  NUM_READ*DATA_WIDTH  packed read data; port k uses slice k
read_busy  out  NUM_READ  scoreboard busy bit of each read index
read_data_v0  out  DATA_WIDTH  contents of register V0_INDEX
write_enable  in  1  write request
write_mode  in  2  0 = overwrite, 1 = OR-merge, 2 = byte-lane merge, 3 = reserved (treated as 0)
write_byte_en  in  DATA_WIDTH/8  lane enables, used only in mode 2
write_reg  in  ADDR_WIDTH  write index
write_data  in  DATA_WIDTH  write data
mark_busy  in  1  set the scoreboard bit of mark_reg (load issued)
mark_reg  in  ADDR_WIDTH  index to mark
clear_req  in  1  start the soft-clear sweep (pulse)
clear_active  out  1  high while the sweep runs
write_ready  out  1  low while the sweep runs; writes are dropped when low

Behaviour:
- Reset (sync, active-high): all registers = 0, all busy bits = 0, FSM = IDLE. As a result clear_active = 0, write_ready = 1, and read_data/read_data_v0/read_busy are all 0.
- Reset mid-sweep aborts the sweep, with the same end state as above.
- Reads are combinational from array state.
  - Index 0 always reads 0 with busy 0.
  - Out-of-range V0_INDEX is a parameter error (elaboration assertion).
- Write commit happens at posedge when write_enable & write_ready & write_reg != 0. New value by mode:
  - mode 0: new = write_data.
  - mode 1: new = write_data | old.
  - mode 2: lane i = write_byte_en[i] ? write_data lane i : old lane i.
- BYPASS=1: any read port (including v0) whose index equals a committing write_reg returns the merged new value in the same cycle. Its read_busy shows the post-edge busy value.
- BYPASS=0: reads show the new value starting the cycle after the edge.
- Scoreboard:
  - A committing write clears busy[write_reg].
  - mark_busy sets busy[mark_reg].
  - Same index, same edge: set wins, so busy = 1.
  - mark_reg = 0 is ignored.
  - mark_busy is honoured during the sweep.
- Sweep FSM has states IDLE and SWEEP, with an internal ADDR_WIDTH-bit counter.
  - IDLE + clear_req: go to SWEEP with counter = 1. clear_active = 1 and write_ready = 0 from the next cycle.
  - SWEEP: each cycle, register[counter] = 0 and busy[counter] = 0, then counter increments.
  - Counter = DEPTH-1 is zeroed, then the FSM returns to IDLE. The sweep takes DEPTH-1 cycles total.
  - clear_req while in SWEEP is ignored (no restart).
  - A write presented while write_ready = 0 is dropped, not queued.
  - Reads during the sweep return current array contents (partially cleared).
- A committing write and a clear_req on the same edge: the write commits first, then the sweep starts next cycle and eventually zeroes that register.
- Widths: all arithmetic is bitwise, with no carries. write_byte_en has DATA_WIDTH/8 bits.

Test Plan:
- Reset, then write R5 = 0x12345678 (mode 0), read port 0 at index 5 and port 1 at index 0 → 0x12345678 and 0x00000000. A write to R0 of 0xFFFFFFFF leaves R0 reading 0.
- R7 = 0x00F0_00F0, mode 1 write 0x0F00_0F00 → R7 = 0x0FF0_0FF0. Then mode 2, byte_en = 4'b0101, data 0xAABBCCDD → R7 = 0x0FBB_0FDD.
- BYPASS=1: write R2 = 0xDEADBEEF while port 0 reads index 2 → read_data and read_data_v0 show 0xDEADBEEF in the same cycle. BYPASS=0 build → old value that cycle, new value the next cycle.
- mark_busy R9 → read_busy for index 9 = 1 next cycle. Write R9 + mark R9 on the same edge → busy stays 1. A write alone → busy 0.
- Fill R1..R31 with nonzero values, pulse clear_req → clear_active high for exactly 31 cycles and write_ready low for those cycles. A write to R3 during the sweep is dropped. Afterwards all registers read 0.
- Assert reset on cycle 10 of the sweep → next cycle clear_active = 0, write_ready = 1, all registers 0. A second clear_req mid-sweep does not extend the sweep.
